// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 codes, FSM states, fault codes, size decode.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ0,
        S_RSP0,
        S_REQ1,
        S_RSP1,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        FLT_OK         = 2'b00,
        FLT_MISALIGNED = 2'b01,
        FLT_ILLEGAL    = 2'b10
    } fault_t;

    // Access size in bytes (1, 2, 4 or 8) from the low two funct3 bits.
    function automatic logic [3:0] size_bytes(input logic [2:0] f3);
        return 4'(4'd1 << f3[1:0]);
    endfunction

    function automatic logic f3_legal(input logic [2:0] f3, input logic we, input logic is64);
        if (we)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (is64 && (f3 == F3_D));
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) ||
               (f3 == F3_HU) || (is64 && ((f3 == F3_D) || (f3 == F3_WU)));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane datapath: byte enables, store lane shift/slice, load merge/shift/extend.
module lsu_align
    import lsu_pkg::*;
#(
    parameter  int unsigned XLEN  = 32,
    localparam int unsigned BYTES = XLEN / 8,
    localparam int unsigned OFF_W = $clog2(BYTES)
) (
    input  logic [2:0]       f3,
    input  logic [OFF_W-1:0] off,
    input  logic [XLEN-1:0]  wdata,
    input  logic [XLEN-1:0]  rdata0,
    input  logic [XLEN-1:0]  rdata1,
    output logic [BYTES-1:0] be0_c,
    output logic [BYTES-1:0] be1_c,
    output logic [XLEN-1:0]  wdata0_c,
    output logic [XLEN-1:0]  wdata1_c,
    output logic [XLEN-1:0]  rdata_c
);

    logic [3:0]         size;
    logic [2*BYTES-1:0] mask;
    logic [2*BYTES-1:0] be_full;
    logic [2*XLEN-1:0]  wsh;
    logic [2*XLEN-1:0]  merged;
    logic [XLEN-1:0]    low;

    assign size     = size_bytes(f3);
    assign mask     = (2*BYTES)'((16'd1 << size) - 16'd1);
    assign be_full  = mask << off;
    assign be0_c    = be_full[BYTES-1:0];
    assign be1_c    = be_full[2*BYTES-1:BYTES];

    // Store data spans two words; only enabled lanes carry data.
    assign wsh = {{XLEN{1'b0}}, wdata} << {off, 3'b000};

    always_comb begin
        wdata0_c = '0;
        wdata1_c = '0;
        for (int i = 0; i < int'(BYTES); i++) begin
            if (be0_c[i]) wdata0_c[8*i +: 8] = wsh[8*i +: 8];
            if (be1_c[i]) wdata1_c[8*i +: 8] = wsh[XLEN + 8*i +: 8];
        end
    end

    assign merged = {rdata1, rdata0} >> {off, 3'b000};
    assign low    = merged[XLEN-1:0];

    always_comb begin
        rdata_c = low;
        case (f3)
            F3_B:    rdata_c = XLEN'($signed(low[7:0]));
            F3_H:    rdata_c = XLEN'($signed(low[15:0]));
            F3_W:    rdata_c = XLEN'($signed(low[31:0]));
            F3_BU:   rdata_c = XLEN'(low[7:0]);
            F3_HU:   rdata_c = XLEN'(low[15:0]);
            F3_WU:   rdata_c = XLEN'(low[31:0]);
            default: rdata_c = low;
        endcase
    end

endmodule

// File: rtl/lsu_multibeat.sv
// Load/store unit: request capture, one- or two-beat req/gnt/rvalid sequencing, fault reporting.
module lsu_multibeat
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN             = 32,
    parameter int unsigned ADDR_W           = 32,
    parameter bit          MISALIGNED_SPLIT = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [2:0]          req_funct3,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                resp_valid,
    output logic [XLEN-1:0]     resp_rdata,
    output logic [1:0]          resp_fault,
    output logic                busy,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN/8-1:0]   mem_be,
    output logic [XLEN-1:0]     mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [XLEN-1:0]     mem_rdata
);

    localparam int unsigned BYTES = XLEN / 8;
    localparam int unsigned OFF_W = $clog2(BYTES);
    localparam logic        IS64  = (XLEN == 64);

    state_t              state, state_d;
    logic [2:0]          f3_q, f3_a;
    logic                we_q, we_a;
    logic [ADDR_W-1:0]   base_q, base_a;
    logic [OFF_W-1:0]    off_q, off_a;
    logic [XLEN-1:0]     wdata_q, wdata_a;
    logic                cross_q;
    fault_t              fault_q, fault_a;
    logic [XLEN-1:0]     rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic                idle, accept;
    logic [3:0]          req_size;
    logic                req_cross;
    fault_t              req_fault;
    logic [BYTES-1:0]    be0_c, be1_c;
    logic [XLEN-1:0]     wdata0_c, wdata1_c, ld_c;

    logic                req_ready_d, resp_valid_d, mem_req_d, mem_we_d;
    logic [XLEN-1:0]     resp_rdata_d, mem_wdata_d;
    logic [1:0]          resp_fault_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic [BYTES-1:0]    mem_be_d;

    assign idle      = (state == S_IDLE);
    assign accept    = idle && req_valid;
    assign req_size  = size_bytes(req_funct3);
    assign req_cross = (5'(req_addr[OFF_W-1:0]) + 5'(req_size)) > 5'(BYTES);

    always_comb begin
        req_fault = FLT_OK;
        if (!f3_legal(req_funct3, req_we, IS64))
            req_fault = FLT_ILLEGAL;
        else if (req_cross && !MISALIGNED_SPLIT)
            req_fault = FLT_MISALIGNED;
    end

    // In IDLE the live request drives the lane logic so beat-0 outputs register on acceptance.
    assign f3_a    = idle ? req_funct3 : f3_q;
    assign we_a    = idle ? req_we : we_q;
    assign base_a  = idle ? {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : base_q;
    assign off_a   = idle ? req_addr[OFF_W-1:0] : off_q;
    assign wdata_a = idle ? req_wdata : wdata_q;
    assign fault_a = idle ? req_fault : fault_q;

    always_comb begin
        rdata0_d = accept ? '0 : rdata0_q;
        rdata1_d = accept ? '0 : rdata1_q;
        if ((state == S_RSP0) && mem_rvalid) rdata0_d = mem_rdata;
        if ((state == S_RSP1) && mem_rvalid) rdata1_d = mem_rdata;
    end

    lsu_align #(.XLEN(XLEN)) u_align (
        .f3       (f3_a),
        .off      (off_a),
        .wdata    (wdata_a),
        .rdata0   (rdata0_d),
        .rdata1   (rdata1_d),
        .be0_c    (be0_c),
        .be1_c    (be1_c),
        .wdata0_c (wdata0_c),
        .wdata1_c (wdata1_c),
        .rdata_c  (ld_c)
    );

    // Next state and next registered outputs.
    always_comb begin
        state_d      = state;
        mem_req_d    = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = '0;
        mem_be_d     = '0;
        mem_wdata_d  = '0;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_fault_d = 2'b00;

        case (state)
            S_IDLE: if (req_valid) state_d = (req_fault != FLT_OK) ? S_DONE : S_REQ0;
            S_REQ0: if (mem_gnt) state_d = S_RSP0;
            S_RSP0: if (mem_rvalid) state_d = cross_q ? S_REQ1 : S_DONE;
            S_REQ1: if (mem_gnt) state_d = S_RSP1;
            S_RSP1: if (mem_rvalid) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        req_ready_d = (state_d == S_IDLE);

        case (state_d)
            S_REQ0: begin
                mem_req_d   = 1'b1;
                mem_we_d    = we_a;
                mem_addr_d  = base_a;
                mem_be_d    = be0_c;
                mem_wdata_d = we_a ? wdata0_c : '0;
            end
            S_REQ1: begin
                mem_req_d   = 1'b1;
                mem_we_d    = we_a;
                mem_addr_d  = base_a + ADDR_W'(BYTES);
                mem_be_d    = be1_c;
                mem_wdata_d = we_a ? wdata1_c : '0;
            end
            S_DONE: begin
                resp_valid_d = 1'b1;
                resp_fault_d = fault_a;
                resp_rdata_d = (!we_a && (fault_a == FLT_OK)) ? ld_c : '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            f3_q       <= '0;
            we_q       <= 1'b0;
            base_q     <= '0;
            off_q      <= '0;
            wdata_q    <= '0;
            cross_q    <= 1'b0;
            fault_q    <= FLT_OK;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_fault <= 2'b00;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
        end else begin
            state <= state_d;
            if (accept) begin
                f3_q    <= req_funct3;
                we_q    <= req_we;
                base_q  <= base_a;
                off_q   <= off_a;
                wdata_q <= req_wdata;
                cross_q <= req_cross;
                fault_q <= req_fault;
            end
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            req_ready  <= req_ready_d;
            busy       <= !req_ready_d;
            resp_valid <= resp_valid_d;
            resp_rdata <= resp_rdata_d;
            resp_fault <= resp_fault_d;
            mem_req    <= mem_req_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_be     <= mem_be_d;
            mem_wdata  <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_lsu_multibeat.sv
// Directed bench for lsu_multibeat (XLEN=32): split instance plus a fault-only instance.
module tb_lsu_multibeat;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, req_we, resp_valid, busy;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic [1:0]  resp_fault;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    logic        n_req_valid, n_req_ready, n_req_we, n_resp_valid, n_busy;
    logic [2:0]  n_req_funct3;
    logic [31:0] n_req_addr, n_req_wdata, n_resp_rdata;
    logic [1:0]  n_resp_fault;
    logic        n_mem_req, n_mem_we, n_mem_gnt, n_mem_rvalid;
    logic [31:0] n_mem_addr, n_mem_wdata, n_mem_rdata;
    logic [3:0]  n_mem_be;

    lsu_multibeat #(.XLEN(32), .ADDR_W(32), .MISALIGNED_SPLIT(1'b1)) dut (
        .clk(clk), .reset(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault), .busy(busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    lsu_multibeat #(.XLEN(32), .ADDR_W(32), .MISALIGNED_SPLIT(1'b0)) dut_nosplit (
        .clk(clk), .reset(rst_n),
        .req_valid(n_req_valid), .req_ready(n_req_ready), .req_we(n_req_we),
        .req_funct3(n_req_funct3), .req_addr(n_req_addr), .req_wdata(n_req_wdata),
        .resp_valid(n_resp_valid), .resp_rdata(n_resp_rdata), .resp_fault(n_resp_fault), .busy(n_busy),
        .mem_req(n_mem_req), .mem_we(n_mem_we), .mem_addr(n_mem_addr), .mem_be(n_mem_be),
        .mem_wdata(n_mem_wdata), .mem_gnt(n_mem_gnt), .mem_rvalid(n_mem_rvalid), .mem_rdata(n_mem_rdata)
    );

    int nvec = 0;
    int nerr = 0;

    logic [31:0] m_addr [2];
    logic [31:0] m_data [2];
    logic [31:0] b_addr [4];
    logic [31:0] b_wd   [4];
    logic [3:0]  b_be   [4];
    logic        b_we   [4];
    int          nb, lat;
    logic        got;
    logic [31:0] r_rdata;
    logic [1:0]  r_fault;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        for (int i = 0; i < 2; i++)
            if (m_addr[i] == a) return m_data[i];
        return 32'hDEAD_BEEF;
    endfunction

    // One access on the split instance; memory grants with the request and answers one cycle later.
    task automatic access(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd);
        logic        rv_next;
        logic [31:0] rv_addr;
        nb = 0; lat = 0; got = 1'b0; r_rdata = '0; r_fault = '0;
        rv_next = 1'b0; rv_addr = '0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        for (int cyc = 1; cyc < 30 && !got; cyc++) begin
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
            if (resp_valid) begin
                got = 1'b1; lat = cyc; r_rdata = resp_rdata; r_fault = resp_fault;
            end else begin
                if (rv_next) begin
                    mem_rvalid = 1'b1; mem_rdata = mem_word(rv_addr); rv_next = 1'b0;
                end
                if (mem_req) begin
                    if (nb < 4) begin
                        b_addr[nb] = mem_addr; b_be[nb] = mem_be; b_wd[nb] = mem_wdata; b_we[nb] = mem_we;
                    end
                    nb++;
                    mem_gnt = 1'b1; rv_next = 1'b1; rv_addr = mem_addr;
                end
            end
            @(negedge clk);
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        chk({tag, ".resp_seen"}, 64'(got), 64'd1);
        chk({tag, ".one_pulse"}, 64'(resp_valid), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        n_req_valid = 0; n_req_we = 0; n_req_funct3 = 0; n_req_addr = 0; n_req_wdata = 0;
        n_mem_gnt = 0; n_mem_rvalid = 0; n_mem_rdata = 0;
        m_addr[0] = 32'h100; m_data[0] = 32'h80FF_1234;
        m_addr[1] = 32'h104; m_data[1] = 32'h1122_3344;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset values
        chk("rst.req_ready", 64'(req_ready), 64'd1);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.mem_req", 64'(mem_req), 64'd0);
        chk("rst.mem_we", 64'(mem_we), 64'd0);
        chk("rst.mem_addr", 64'(mem_addr), 64'd0);
        chk("rst.mem_be", 64'(mem_be), 64'd0);
        chk("rst.mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst.resp", 64'({resp_valid, resp_fault, resp_rdata}), 64'd0);

        // lb @0x103 of 0x80FF1234 -> byte 0x80 sign-extended
        access("lb", 1'b0, 3'b000, 32'h103, 32'h0);
        chk("lb.beats", 64'(nb), 64'd1);
        chk("lb.addr", 64'(b_addr[0]), 64'h100);
        chk("lb.be", 64'(b_be[0]), 64'b1000);
        chk("lb.we", 64'(b_we[0]), 64'd0);
        chk("lb.rdata", 64'(r_rdata), 64'hFFFF_FF80);
        chk("lb.fault", 64'(r_fault), 64'd0);
        chk("lb.lat", 64'(lat), 64'd3);

        // lhu @0x102 -> 0x80FF zero-extended
        access("lhu", 1'b0, 3'b101, 32'h102, 32'h0);
        chk("lhu.be", 64'(b_be[0]), 64'b1100);
        chk("lhu.rdata", 64'(r_rdata), 64'h0000_80FF);

        // lw @0x102 split across 0x100/0x104
        m_data[0] = 32'hAABB_CCDD;
        access("lw_split", 1'b0, 3'b010, 32'h102, 32'h0);
        chk("lw_split.beats", 64'(nb), 64'd2);
        chk("lw_split.addr0", 64'(b_addr[0]), 64'h100);
        chk("lw_split.be0", 64'(b_be[0]), 64'b1100);
        chk("lw_split.addr1", 64'(b_addr[1]), 64'h104);
        chk("lw_split.be1", 64'(b_be[1]), 64'b0011);
        chk("lw_split.rdata", 64'(r_rdata), 64'h3344_AABB);
        chk("lw_split.lat", 64'(lat), 64'd5);

        // sh @0x103: upper wdata bits must not leak into unenabled lanes
        access("sh_split", 1'b1, 3'b001, 32'h103, 32'hFFFF_1234);
        chk("sh_split.beats", 64'(nb), 64'd2);
        chk("sh_split.addr0", 64'(b_addr[0]), 64'h100);
        chk("sh_split.be0", 64'(b_be[0]), 64'b1000);
        chk("sh_split.wd0", 64'(b_wd[0]), 64'h3400_0000);
        chk("sh_split.we0", 64'(b_we[0]), 64'd1);
        chk("sh_split.addr1", 64'(b_addr[1]), 64'h104);
        chk("sh_split.be1", 64'(b_be[1]), 64'b0001);
        chk("sh_split.wd1", 64'(b_wd[1]), 64'h0000_0012);
        chk("sh_split.rdata", 64'(r_rdata), 64'd0);

        // lw @0xFFFFFFFE: second beat wraps to address 0
        m_addr[0] = 32'hFFFF_FFFC; m_data[0] = 32'h5566_7788;
        m_addr[1] = 32'h0000_0000; m_data[1] = 32'h99AA_BBCC;
        access("lw_wrap", 1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0);
        chk("lw_wrap.addr0", 64'(b_addr[0]), 64'hFFFF_FFFC);
        chk("lw_wrap.addr1", 64'(b_addr[1]), 64'h0);
        chk("lw_wrap.rdata", 64'(r_rdata), 64'hBBCC_5566);

        // Illegal funct3 for load (111) and store (100): no memory traffic
        access("ld_f3_111", 1'b0, 3'b111, 32'h100, 32'h0);
        chk("ld_f3_111.fault", 64'(r_fault), 64'b10);
        chk("ld_f3_111.beats", 64'(nb), 64'd0);
        chk("ld_f3_111.lat", 64'(lat), 64'd1);
        access("st_f3_100", 1'b1, 3'b100, 32'h100, 32'h55);
        chk("st_f3_100.fault", 64'(r_fault), 64'b10);
        chk("st_f3_100.beats", 64'(nb), 64'd0);

        // No-split instance: lw @0x101 faults without a memory request
        @(negedge clk);
        n_req_valid = 1'b1; n_req_we = 1'b0; n_req_funct3 = 3'b010; n_req_addr = 32'h101;
        @(negedge clk);
        n_req_valid = 1'b0;
        chk("nosplit.resp_valid", 64'(n_resp_valid), 64'd1);
        chk("nosplit.fault", 64'(n_resp_fault), 64'b01);
        chk("nosplit.rdata", 64'(n_resp_rdata), 64'd0);
        chk("nosplit.mem_req", 64'(n_mem_req), 64'd0);
        @(negedge clk);
        chk("nosplit.pulse_end", 64'(n_resp_valid), 64'd0);
        chk("nosplit.ready", 64'(n_req_ready), 64'd1);

        // Request held stable without gnt, then dropped asynchronously by reset
        m_addr[0] = 32'h100; m_data[0] = 32'h80FF_1234;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b100; req_addr = 32'h101;
        @(negedge clk);
        req_valid = 1'b0;
        chk("stall.mem_req", 64'(mem_req), 64'd1);
        chk("stall.busy", 64'(busy), 64'd1);
        @(negedge clk);
        chk("stall.held", 64'({mem_req, mem_be, mem_addr}), 64'({1'b1, 4'b0010, 32'h100}));
        rst_n = 1'b0;
        #1;
        chk("stall.async_drop", 64'(mem_req), 64'd0);
        chk("stall.async_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset while waiting in RSP0; late rvalid/gnt in IDLE are ignored
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rsp0.mem_req", 64'(mem_req), 64'd1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("rsp0.busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rsp0.ready", 64'(req_ready), 64'd1);
        chk("rsp0.mem_req", 64'(mem_req), 64'd0);
        mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        mem_rvalid = 1'b0; mem_gnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("rsp0.no_resp", 64'({resp_valid, mem_req, busy}), 64'd0);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
